// File: rtl/pseq_pkg.sv
// Shared types and constants for the four-phase pulse sequencer.
package pseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [1:0] PH_P1 = 2'd0;
  localparam logic [1:0] PH_P2 = 2'd1;
  localparam logic [1:0] PH_P3 = 2'd2;
  localparam logic [1:0] PH_P4 = 2'd3;

  localparam int CYC_CNT_W = 16;

endpackage

// File: rtl/pseq_timer.sv
// Loadable down-counter with hold; o_expire flags a count of zero.
module pseq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/phase_pulse_sequencer.sv
// Four-phase non-overlapping pulse sequencer with width/gap/burst control.
// Define PSEQ_CYCLE_CNT_EN to add the cyc_cnt completed-cycle counter output.
module phase_pulse_sequencer
  import pseq_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   width,
  input  logic [CNT_W-1:0]   gap,
  input  logic [BURST_W-1:0] burst,
  output logic               busy,
  output logic               done,
  output logic               p1,
  output logic               p2,
  output logic               p3,
  output logic               p4,
  output logic               p23,
  output logic [1:0]         phase
`ifdef PSEQ_CYCLE_CNT_EN
  ,
  output logic [CYC_CNT_W-1:0] cyc_cnt
`endif
);

  state_e             r_state, w_state_nxt;
  logic [1:0]         r_phase, w_phase_nxt;
  logic [CNT_W-1:0]   r_width_m1, r_gap, w_width_m1_in, w_tmr_val;
  logic [BURST_W-1:0] r_burst, r_burst_cnt, w_burst_cnt_nxt;
  logic               r_stop, w_stop_nxt;
  logic               w_tmr_load, w_tmr_expire;
  logic               w_start_acc, w_cyc_end, w_term, w_done_nxt;
  logic               r_busy, r_done, r_p23;
  logic [3:0]         r_pulse, w_pulse_nxt;

  assign w_width_m1_in = (width == '0) ? '0 : width - CNT_W'(1);
  assign w_term = r_stop || stop ||
                  ((r_burst != '0) && (r_burst_cnt == r_burst - BURST_W'(1)));

  pseq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .i_clear    (clear),
    .i_en       (en),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_tmr_expire)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_burst_cnt_nxt = r_burst_cnt;
    w_stop_nxt      = r_stop;
    w_tmr_load      = 1'b0;
    w_tmr_val       = '0;
    w_start_acc     = 1'b0;
    w_cyc_end       = 1'b0;
    w_done_nxt      = 1'b0;
    w_pulse_nxt     = '0;

    if ((r_state != IDLE) && stop) w_stop_nxt = 1'b1;

    // Every transition waits on en, so en=0 freezes state, phase and counts.
    case (r_state)
      IDLE: begin
        if (en && start) begin
          w_start_acc     = 1'b1;
          w_state_nxt     = PULSE;
          w_phase_nxt     = PH_P1;
          w_tmr_load      = 1'b1;
          w_tmr_val       = w_width_m1_in;
          w_burst_cnt_nxt = '0;
          w_stop_nxt      = stop;
        end
      end
      PULSE: begin
        if (en && w_tmr_expire) begin
          if (r_gap != '0) begin
            w_state_nxt = GAP;
            w_tmr_load  = 1'b1;
            w_tmr_val   = r_gap - CNT_W'(1);
          end else if (r_phase == PH_P4) begin
            w_cyc_end = 1'b1;
          end else begin
            w_phase_nxt = r_phase + 2'd1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = r_width_m1;
          end
        end
      end
      GAP: begin
        if (en && w_tmr_expire) begin
          if (r_phase == PH_P4) begin
            w_cyc_end = 1'b1;
          end else begin
            w_state_nxt = PULSE;
            w_phase_nxt = r_phase + 2'd1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = r_width_m1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_cyc_end) begin
      if (w_term) begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_stop_nxt  = 1'b0;
      end else begin
        w_burst_cnt_nxt = r_burst_cnt + BURST_W'(1);
        w_state_nxt     = PULSE;
        w_phase_nxt     = PH_P1;
        w_tmr_load      = 1'b1;
        w_tmr_val       = r_width_m1;
      end
    end

    if (en && (w_state_nxt == PULSE)) w_pulse_nxt[w_phase_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= IDLE;
      r_phase     <= PH_P1;
      r_burst_cnt <= '0;
      r_stop      <= 1'b0;
      r_width_m1  <= '0;
      r_gap       <= '0;
      r_burst     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pulse     <= '0;
      r_p23       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_stop      <= w_stop_nxt;
      if (w_start_acc) begin
        r_width_m1 <= w_width_m1_in;
        r_gap      <= gap;
        r_burst    <= burst;
      end
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
      r_pulse <= w_pulse_nxt;
      r_p23   <= w_pulse_nxt[1] | w_pulse_nxt[2];
    end
  end

`ifdef PSEQ_CYCLE_CNT_EN
  logic [CYC_CNT_W-1:0] r_cyc_cnt;

  always_ff @(posedge clk) begin
    if (clear || w_start_acc) begin
      r_cyc_cnt <= '0;
    end else if (w_cyc_end && (r_cyc_cnt != '1)) begin
      r_cyc_cnt <= r_cyc_cnt + CYC_CNT_W'(1);
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

  assign busy  = r_busy;
  assign done  = r_done;
  assign p1    = r_pulse[0];
  assign p2    = r_pulse[1];
  assign p3    = r_pulse[2];
  assign p4    = r_pulse[3];
  assign p23   = r_p23;
  assign phase = r_phase;

endmodule

// File: tb/tb_phase_pulse_sequencer.sv
// Directed bench for phase_pulse_sequencer; observes {done,busy,p23,p4,p3,p2,p1}.
module tb_phase_pulse_sequencer;

  logic       clk = 1'b0;
  logic       clear, en, start, stop;
  logic [7:0] width, gap, burst;
  logic       busy, done, p1, p2, p3, p4, p23;
  logic [1:0] phase;
`ifdef PSEQ_CYCLE_CNT_EN
  logic [15:0] cyc_cnt;
`endif
  logic [6:0] obs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_pulse_sequencer #(.CNT_W(8), .BURST_W(8)) dut (
    .clk   (clk),
    .clear (clear),
    .en    (en),
    .start (start),
    .stop  (stop),
    .width (width),
    .gap   (gap),
    .burst (burst),
    .busy  (busy),
    .done  (done),
    .p1    (p1),
    .p2    (p2),
    .p3    (p3),
    .p4    (p4),
    .p23   (p23),
    .phase (phase)
`ifdef PSEQ_CYCLE_CNT_EN
    ,
    .cyc_cnt (cyc_cnt)
`endif
  );

  assign obs = {done, busy, p23, p4, p3, p2, p1};

  function automatic logic [6:0] mk(input logic d, input logic b, input logic [3:0] p);
    return {d, b, p[1] | p[2], p[3], p[2], p[1], p[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge where the first post-start sample (k=1) is visible.
  task automatic start_run(input logic [7:0] w, input logic [7:0] g,
                           input logic [7:0] b, input logic s);
    width = w; gap = g; burst = b; start = 1'b1; stop = s;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0;
    width = 8'd3; gap = 8'd3; burst = 8'd0;
    @(negedge clk);
    tick();
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 7'b0);
    end
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_phase: got %0d expected 0", phase);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: got %b expected %b", obs, 7'b0);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", obs, 7'b0);
    end
  endtask

  task automatic test_basic();
    logic [6:0] exp;
    start_run(8'd2, 8'd1, 8'd1, 1'b0);
    width = 8'd7; gap = 8'd5; burst = 8'd3;
    for (int k = 1; k <= 15; k++) begin
      exp = mk(k == 13, k <= 12,
               (k <= 12 && ((k - 1) % 3) < 2) ? 4'(1 << ((k - 1) / 3)) : 4'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic k=%0d: got %b expected %b", k, obs, exp);
      end
      if (k == 4) begin
        checks++;
        if (phase !== 2'd1) begin
          errors++;
          $display("FAIL basic_phase_p2: got %0d expected 1", phase);
        end
      end
      if (k == 13) begin
        checks++;
        if (phase !== 2'd3) begin
          errors++;
          $display("FAIL basic_phase_last: got %0d expected 3", phase);
        end
      end
      tick();
    end
`ifdef PSEQ_CYCLE_CNT_EN
    checks++;
    if (cyc_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_cyc_cnt: got %0d expected 1", cyc_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start_run(8'd0, 8'd0, 8'd2, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      exp = mk(k == 9, k <= 8, (k <= 8) ? 4'(1 << ((k - 1) % 4)) : 4'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back k=%0d: got %b expected %b", k, obs, exp);
      end
      checks++;
      if ($countones({p4, p3, p2, p1}) > 1 || (done && (p1 | p2 | p3 | p4))) begin
        errors++;
        $display("FAIL overlap k=%0d: got %b expected at most one pulse", k, obs);
      end
      tick();
    end
  endtask

  task automatic test_continuous();
    logic [6:0] exp;
    int pos;
    start_run(8'd3, 8'd2, 8'd0, 1'b0);
    for (int k = 1; k <= 103; k++) begin
      pos = (k - 1) % 20;
      exp = mk(k == 101, k <= 100,
               (k <= 100 && (pos % 5) < 3) ? 4'(1 << (pos / 5)) : 4'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL continuous k=%0d: got %b expected %b", k, obs, exp);
      end
      stop = (k == 87);
      tick();
    end
    stop = 1'b0;
`ifdef PSEQ_CYCLE_CNT_EN
    checks++;
    if (cyc_cnt !== 16'd5) begin
      errors++;
      $display("FAIL continuous_cyc_cnt: got %0d expected 5", cyc_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    logic [6:0] exp;
    logic [3:0] p;
    start_run(8'd4, 8'd0, 8'd1, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      if (k <= 4)                               p = 4'b0001;
      else if ((k >= 5 && k <= 6) || (k >= 11 && k <= 12)) p = 4'b0010;
      else if (k >= 13 && k <= 16)              p = 4'b0100;
      else if (k >= 17 && k <= 20)              p = 4'b1000;
      else                                      p = 4'b0000;
      exp = mk(k == 21, k <= 20, p);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stall k=%0d: got %b expected %b", k, obs, exp);
      end
      en = !(k >= 6 && k <= 9);
      tick();
    end
    en = 1'b1;
  endtask

  task automatic test_clear_mid();
    logic [6:0] exp;
    start_run(8'd2, 8'd1, 8'd1, 1'b0);
    for (int k = 1; k <= 7; k++) tick();
    checks++;
    if (obs !== mk(1'b0, 1'b1, 4'b0100)) begin
      errors++;
      $display("FAIL clear_pre_p3: got %b expected %b", obs, mk(1'b0, 1'b1, 4'b0100));
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (obs !== 7'b0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL clear_abort: got %b phase %0d expected %b phase 0", obs, phase, 7'b0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL clear_no_done k=%0d: got %b expected %b", k, obs, 7'b0);
      end
    end
`ifdef PSEQ_CYCLE_CNT_EN
    checks++;
    if (cyc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clear_cyc_cnt: got %0d expected 0", cyc_cnt);
    end
`endif
    start_run(8'd1, 8'd0, 8'd1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      exp = mk(k == 5, k <= 4, (k <= 4) ? 4'(1 << (k - 1)) : 4'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL clear_restart k=%0d: got %b expected %b", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_start_stop();
    logic [6:0] exp;
    start_run(8'd1, 8'd1, 8'd0, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      exp = mk(k == 9, k <= 8,
               (k <= 8 && ((k - 1) % 2) == 0) ? 4'(1 << ((k - 1) / 2)) : 4'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL start_stop k=%0d: got %b expected %b", k, obs, exp);
      end
      start = (k == 3);
      tick();
    end
    start = 1'b0;
`ifdef PSEQ_CYCLE_CNT_EN
    checks++;
    if (cyc_cnt !== 16'd1) begin
      errors++;
      $display("FAIL start_stop_cyc_cnt: got %0d expected 1", cyc_cnt);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_continuous();
    test_stall();
    test_clear_mid();
    test_start_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_pulse_sequencer.md
Name: phase_pulse_sequencer

Overview:
Synchronous, single-clock four-phase pulse sequencer. Generates the non-overlapping p1/p2/p3/p4 pulse train and the p23 composite with programmable pulse width and dead time. Supports a start/stop handshake, a burst count and a global enable. Sits between the control logic and the counter datapath that consumes the phase pulses.

Parameters:
CNT_W, 8, width of the pulse-width and gap configuration fields
BURST_W, 8, width of the burst-count field

Ports:
clk  input  1  system clock; all logic on posedge
clear  input  1  synchronous active-high reset
en  input  1  global enable; low freezes the sequence and forces pulses low
start  input  1  request to begin a sequence; sampled only in IDLE
stop  input  1  request to end after the current four-phase cycle
width  input  CNT_W  clocks each phase pulse is high; 0 is treated as 1
gap  input  CNT_W  dead-time clocks after each pulse; 0 means no gap
burst  input  BURST_W  number of four-phase cycles to run; 0 means continuous
busy  output  1  high from start acceptance until return to IDLE
done  output  1  single-cycle pulse on return to IDLE
p1, p2, p3, p4  output  1 each  phase pulses
p23  output  1  equals p2 OR p3 in the same cycle
phase  output  2  index of current or last phase (0 to 3)

Behaviour:
- Reset: the block uses a synchronous active-high reset. When clear=1 at posedge, busy, done, p1-p4, p23 and phase all go to 0. The FSM goes to IDLE, and the stop latch and all counters are zeroed. Reset mid-operation aborts immediately, with no done pulse.
- FSM states: IDLE, PULSE, GAP.
  - A 2-bit phase register steps through the phases 0, 1, 2 and 3.
  - A timer counts down within the PULSE and GAP states.
- Start acceptance:
  - Condition: start=1, en=1 and state is IDLE.
  - On acceptance, width, gap and burst are latched into shadow registers. Input changes during the run are ignored.
  - Next cycle: busy=1, state=PULSE, phase=0, and p1 goes high.
- Phase timing:
  - PULSE lasts max(width,1) clocks. During PULSE, exactly one of p1-p4 is high, selected by phase.
  - GAP then lasts gap clocks with all pulses low. When gap=0, GAP is skipped and the next pulse follows directly.
  - One four-phase cycle takes 4*(max(width,1)+gap) clocks.
- Pulse outputs are registered and therefore glitch-free. No two of p1-p4 are ever high in the same cycle.
- Cycle end: a cycle ends at the last clock of phase 3's GAP, or of phase 3's PULSE if gap=0. At that point:
  - If the stop latch is set, or the burst count reaches the latched burst (burst≠0), go to IDLE. Drop busy and pulse done=1 for one cycle.
  - Otherwise increment the burst count and restart at phase 0.
- stop handling:
  - stop=1 while busy sets the stop latch. The current cycle always completes; it is never truncated.
  - stop in IDLE is ignored.
  - start and stop in the same IDLE cycle: the start is accepted, the stop is latched, and exactly one cycle runs.
- start while busy is ignored.
- en=0 behaviour:
  - State, timer, phase and burst count freeze, and p1-p4/p23 read 0 from the next cycle.
  - busy holds its value.
  - When en returns to 1, the sequence resumes with the remaining timer count. The interrupted pulse is extended by the stall, not restarted.
- Counter arithmetic:
  - The timer is CNT_W bits. The burst count is BURST_W bits.
  - In continuous mode the burst counter wraps modulo 2^BURST_W and has no effect on termination.
- done is never asserted at the same time as any pulse.

Optional Feature:
PSEQ_CYCLE_CNT_EN
- Defined: adds output port cyc_cnt [15:0], the number of completed four-phase cycles since the last start acceptance.
  - Cleared on clear and on start acceptance.
  - Increments at each cycle end and saturates at 16'hFFFF.
  - Holds its value in IDLE until the next start.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package pseq_pkg holds:
  - the FSM state typedef (IDLE, PULSE, GAP);
  - phase constants PH_P1=0, PH_P2=1, PH_P3=2, PH_P4=3;
  - the cycle-counter width constant (16).
- One sub-module, pseq_timer. It is a loadable CNT_W down-counter with load, hold (en) and an expire flag. It is instantiated once and reloaded at every PULSE/GAP entry.

Test Plan:
- width=2, gap=1, burst=1, start pulsed at edge T0:
  - p1 high at T1-T2, p2 at T4-T5, p3 at T7-T8 and p4 at T10-T11.
  - p23 high at T4-T8 except T6.
  - done=1 at T13; busy high T1-T12.
- width=0, gap=0, burst=2: each pulse lasts 1 clock, back to back. The sequence is p1,p2,p3,p4,p1,p2,p3,p4, followed by done 1 cycle after the 8th pulse. Confirm no overlap.
- burst=0, width=3, gap=2: the sequence runs continuously. stop asserted during phase 1 of cycle 5 lets cycle 5 complete, then done fires; with PSEQ_CYCLE_CNT_EN defined, cyc_cnt=5.
- en=0 held for 4 clocks mid-p2 (width=4, after 2 clocks of p2):
  - p2 drops for the stall and then resumes for its remaining 2 clocks.
  - Total cycle length is 4 clocks longer; busy stays 1 throughout.
- clear asserted mid-p3: on the next edge all outputs are 0, state is IDLE and no done pulse occurs. A new start then begins at p1 with freshly latched config.
- start=1 and stop=1 together in IDLE with burst=0: exactly one four-phase cycle runs, then done. A second start during busy is ignored (no restart, pulse order unchanged).
